// File: rtl/npu_dispatch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npu_dispatch_ctrl_pkg
// Description : Shared constants for the matr dispatch controller: R-type
//               opcode, matr funct7 code, FSM state encoding and the matr
//               decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package npu_dispatch_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE    = 7'b0110011;
  localparam logic [6:0] MATR_FUNCT7 = 7'b0000011;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  // True when the instruction fields identify a matr R-type operation
  function automatic logic is_matr(input logic [6:0] opcode,
                                   input logic [6:0] funct7,
                                   input logic [6:0] matr_code);
    return (opcode == OP_RTYPE) && (funct7 == matr_code);
  endfunction

endpackage
`default_nettype wire

// File: rtl/npu_dispatch_ctrl_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : npu_timeout_cnt
// Description : Watchdog counter for an outstanding NPU operation. Cleared
//               when an operation starts, counts while enabled and flags
//               expiry in the cycle the count sits at TIMEOUT-1.
// Revision    : 1.0 - initial release
// ============================================================================
module npu_timeout_cnt #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int              c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT - 1);

  logic [c_cnt_w-1:0] r_cnt;

  assign o_expire = i_en && (r_cnt == c_last);

  // Count enabled cycles, saturating at the expiry value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/npu_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : npu_dispatch_ctrl
// Description : Detects matr instructions in ID, freezes the pipeline while
//               the NPU executes them, and retires the result through a
//               dedicated one-cycle writeback strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module npu_dispatch_ctrl #(
  parameter logic [6:0] MATR_FUNCT7 = npu_dispatch_ctrl_pkg::MATR_FUNCT7,
  parameter int         TIMEOUT     = 1024,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_id_valid,
  input  logic [6:0]       i_id_opcode,
  input  logic [6:0]       i_id_funct7,
  input  logic [4:0]       i_id_rd,
  input  logic [31:0]      i_rs1_data,
  input  logic [31:0]      i_rs2_data,
  input  logic             i_flush,
  output logic             o_npu_stall,
  output logic             o_ctrl_src,
  output logic             o_npu_req_valid,
  input  logic             i_npu_req_ready,
  output logic [31:0]      o_npu_req_a,
  output logic [31:0]      o_npu_req_b,
  input  logic             i_npu_done,
  input  logic [31:0]      i_npu_result,
  output logic             o_wb_valid,
  output logic [4:0]       o_wb_rd,
  output logic [31:0]      o_wb_data,
  output logic             o_npu_err,
  output logic [CNT_W-1:0] o_op_count
);

  import npu_dispatch_ctrl_pkg::*;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [31:0]      r_req_a;
  logic [31:0]      r_req_b;
  logic [4:0]       r_rd;
  logic             r_drop;
  logic             r_wb_valid;
  logic [4:0]       r_wb_rd;
  logic [31:0]      r_wb_data;
  logic             r_err;
  logic [CNT_W-1:0] r_op_count;

  logic w_in_idle, w_in_issue, w_in_wait, w_in_wb;
  logic w_hit, w_hs, w_expire, w_drop_eff;
  logic w_done_ok, w_timeout, w_wait_exit;

  assign w_in_idle  = (r_state == S_IDLE);
  assign w_in_issue = (r_state == S_ISSUE);
  assign w_in_wait  = (r_state == S_WAIT);
  assign w_in_wb    = (r_state == S_WB);

  // rst_n gates the hit so every output reads 0 while reset is held
  assign w_hit = rst_n && w_in_idle && i_id_valid && !i_flush &&
                 is_matr(i_id_opcode, i_id_funct7, MATR_FUNCT7);
  assign w_hs  = w_in_issue && i_npu_req_ready;

  // A flush arriving in the same WAIT cycle as completion still squashes it
  assign w_drop_eff  = r_drop || i_flush;
  assign w_wait_exit = w_in_wait && (i_npu_done || w_expire);
  // Done has priority over a coincident expiry
  assign w_done_ok   = w_in_wait && i_npu_done && !w_drop_eff;
  assign w_timeout   = w_expire && ((w_in_issue && !w_hs && !i_flush) ||
                                    (w_in_wait && !i_npu_done));

  npu_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_hit),
    .i_en     (w_in_issue || w_in_wait),
    .o_expire (w_expire)
  );

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_hit) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_hs)          w_state_nxt = S_WAIT;
        else if (i_flush)  w_state_nxt = S_IDLE;
        else if (w_expire) w_state_nxt = S_WB;
      end
      S_WAIT: begin
        if (i_npu_done || w_expire) w_state_nxt = w_drop_eff ? S_IDLE : S_WB;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and operand/destination latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_req_a <= '0;
      r_req_b <= '0;
      r_rd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hit) begin
        r_req_a <= i_rs1_data;
        r_req_b <= i_rs2_data;
        r_rd    <= i_id_rd;
      end
    end
  end

  // Drop flag: the NPU cannot be cancelled, so a squashed op is tracked here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop <= 1'b0;
    end else if (w_in_idle || w_wait_exit) begin
      r_drop <= 1'b0;
    end else if ((w_hs && i_flush) || (w_in_wait && i_flush)) begin
      r_drop <= 1'b1;
    end
  end

  // Writeback strobe/data, loaded only for the single WB cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else if (w_state_nxt == S_WB) begin
      r_wb_valid <= 1'b1;
      r_wb_rd    <= r_rd;
      r_wb_data  <= w_done_ok ? i_npu_result : 32'd0;
    end else begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end
  end

  // Sticky timeout flag and completed-operation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err      <= 1'b0;
      r_op_count <= '0;
    end else begin
      if (w_timeout) r_err <= 1'b1;
      if (w_done_ok) r_op_count <= r_op_count + 1'b1;
    end
  end

  assign o_npu_stall     = w_hit || w_in_issue || w_in_wait;
  assign o_ctrl_src      = w_in_wb;
  assign o_npu_req_valid = w_in_issue;
  assign o_npu_req_a     = r_req_a;
  assign o_npu_req_b     = r_req_b;
  assign o_wb_valid      = r_wb_valid;
  assign o_wb_rd         = r_wb_rd;
  assign o_wb_data       = r_wb_data;
  assign o_npu_err       = r_err;
  assign o_op_count      = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_npu_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_npu_dispatch_ctrl
// Description : Directed self-checking bench for npu_dispatch_ctrl with a
//               writeback scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npu_dispatch_ctrl;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             id_valid = 1'b0;
  logic [6:0]       id_opcode = '0;
  logic [6:0]       id_funct7 = '0;
  logic [4:0]       id_rd = '0;
  logic [31:0]      rs1_data = '0;
  logic [31:0]      rs2_data = '0;
  logic             flush = 1'b0;
  logic             npu_stall, ctrl_src, npu_req_valid;
  logic             npu_req_ready = 1'b0;
  logic [31:0]      npu_req_a, npu_req_b;
  logic             npu_done = 1'b0;
  logic [31:0]      npu_result = '0;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data;
  logic             npu_err;
  logic [CNT_W-1:0] op_count;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;
  int hs0     = 0;
  logic [36:0] sb_q[$];

  npu_dispatch_ctrl #(
    .MATR_FUNCT7 (7'b0000011),
    .TIMEOUT     (16),
    .CNT_W       (CNT_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_id_valid      (id_valid),
    .i_id_opcode     (id_opcode),
    .i_id_funct7     (id_funct7),
    .i_id_rd         (id_rd),
    .i_rs1_data      (rs1_data),
    .i_rs2_data      (rs2_data),
    .i_flush         (flush),
    .o_npu_stall     (npu_stall),
    .o_ctrl_src      (ctrl_src),
    .o_npu_req_valid (npu_req_valid),
    .i_npu_req_ready (npu_req_ready),
    .o_npu_req_a     (npu_req_a),
    .o_npu_req_b     (npu_req_b),
    .i_npu_done      (npu_done),
    .i_npu_result    (npu_result),
    .o_wb_valid      (wb_valid),
    .o_wb_rd         (wb_rd),
    .o_wb_data       (wb_data),
    .o_npu_err       (npu_err),
    .o_op_count      (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_matr(input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    id_valid  = 1'b1;
    id_opcode = 7'b0110011;
    id_funct7 = 7'b0000011;
    id_rd     = rd;
    rs1_data  = a;
    rs2_data  = b;
  endtask

  task automatic clr_id();
    id_valid  = 1'b0;
    id_opcode = '0;
    id_funct7 = '0;
    id_rd     = '0;
    rs1_data  = '0;
    rs2_data  = '0;
  endtask

  // Handshake counter and writeback scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    logic [36:0] e;
    if (npu_req_valid && npu_req_ready) hs_cnt++;
    if (wb_valid) begin
      if (sb_q.size() == 0) begin
        chk("wb_unexpected", {31'd0, wb_valid}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_wb_rd", {27'd0, wb_rd}, {27'd0, e[36:32]});
        chk("sb_wb_data", wb_data, e[31:0]);
      end
    end
  end

  initial begin
    // Reset state
    tick();
    chk("rst_stall", {31'd0, npu_stall}, 0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 0);
    chk("rst_err", {31'd0, npu_err}, 0);
    chk("rst_opcount", {16'd0, op_count}, 0);
    rst_n = 1'b1;
    tick();

    // Basic operation
    set_matr(5'd5, 32'h100, 32'h200);
    #1;
    chk("basic_stall_hit", {31'd0, npu_stall}, 1);
    chk("basic_reqv_hit", {31'd0, npu_req_valid}, 0);
    tick();
    clr_id();
    npu_req_ready = 1'b1;
    #1;
    chk("basic_reqv_issue", {31'd0, npu_req_valid}, 1);
    chk("basic_req_a", npu_req_a, 32'h100);
    chk("basic_req_b", npu_req_b, 32'h200);
    chk("basic_stall_issue", {31'd0, npu_stall}, 1);
    tick();
    npu_req_ready = 1'b0;
    #1;
    chk("basic_reqv_wait", {31'd0, npu_req_valid}, 0);
    chk("basic_stall_wait", {31'd0, npu_stall}, 1);
    tick();
    tick();
    tick();
    npu_done = 1'b1;
    npu_result = 32'hDEADBEEF;
    sb_q.push_back({5'd5, 32'hDEADBEEF});
    tick();
    npu_done = 1'b0;
    #1;
    chk("basic_wb_valid", {31'd0, wb_valid}, 1);
    chk("basic_ctrl_src", {31'd0, ctrl_src}, 1);
    chk("basic_stall_wb", {31'd0, npu_stall}, 0);
    chk("basic_wb_rd", {27'd0, wb_rd}, 5);
    chk("basic_wb_data", wb_data, 32'hDEADBEEF);
    tick();
    chk("basic_wb_valid_after", {31'd0, wb_valid}, 0);
    chk("basic_ctrl_after", {31'd0, ctrl_src}, 0);
    chk("basic_wb_rd_after", {27'd0, wb_rd}, 0);
    chk("basic_wb_data_after", wb_data, 0);
    chk("basic_opcount", {16'd0, op_count}, 1);

    // Backpressure: ready low for three ISSUE cycles
    set_matr(5'd7, 32'h100, 32'h200);
    hs0 = hs_cnt;
    tick();
    clr_id();
    for (int i = 0; i < 4; i++) begin
      npu_req_ready = (i == 3);
      #1;
      chk("bp_reqv", {31'd0, npu_req_valid}, 1);
      chk("bp_req_a", npu_req_a, 32'h100);
      chk("bp_req_b", npu_req_b, 32'h200);
      tick();
    end
    npu_req_ready = 1'b0;
    chk("bp_one_hs", hs_cnt - hs0, 1);
    npu_done = 1'b1;
    npu_result = 32'h12345678;
    sb_q.push_back({5'd7, 32'h12345678});
    tick();
    npu_done = 1'b0;
    #1;
    chk("bp_wb_valid", {31'd0, wb_valid}, 1);
    tick();
    chk("bp_opcount", {16'd0, op_count}, 2);

    // Flush in ISSUE before ready
    set_matr(5'd9, 32'h300, 32'h400);
    hs0 = hs_cnt;
    tick();
    clr_id();
    flush = 1'b1;
    #1;
    chk("fi_reqv", {31'd0, npu_req_valid}, 1);
    tick();
    flush = 1'b0;
    #1;
    chk("fi_idle_stall", {31'd0, npu_stall}, 0);
    chk("fi_idle_reqv", {31'd0, npu_req_valid}, 0);
    chk("fi_no_hs", hs_cnt - hs0, 0);
    tick();
    chk("fi_no_wb", {31'd0, wb_valid}, 0);

    // Flush in WAIT: done consumed silently
    set_matr(5'd10, 32'h500, 32'h600);
    tick();
    clr_id();
    npu_req_ready = 1'b1;
    tick();
    npu_req_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    npu_done = 1'b1;
    npu_result = 32'h0000AAAA;
    tick();
    npu_done = 1'b0;
    #1;
    chk("fw_no_wb", {31'd0, wb_valid}, 0);
    chk("fw_stall", {31'd0, npu_stall}, 0);
    chk("fw_opcount", {16'd0, op_count}, 2);

    // Timeout after 16 cycles in ISSUE/WAIT
    set_matr(5'd11, 32'h700, 32'h800);
    tick();
    clr_id();
    npu_req_ready = 1'b1;
    tick();
    npu_req_ready = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("to_err_before", {31'd0, npu_err}, 0);
    chk("to_stall_before", {31'd0, npu_stall}, 1);
    sb_q.push_back({5'd11, 32'd0});
    tick();
    chk("to_err_set", {31'd0, npu_err}, 1);
    chk("to_wb_valid", {31'd0, wb_valid}, 1);
    chk("to_wb_data", wb_data, 0);
    tick();
    npu_done = 1'b1;
    npu_result = 32'h55;
    tick();
    npu_done = 1'b0;
    #1;
    chk("to_late_done_wb", {31'd0, wb_valid}, 0);
    chk("to_late_done_stall", {31'd0, npu_stall}, 0);
    chk("to_opcount", {16'd0, op_count}, 2);
    chk("to_err_sticky", {31'd0, npu_err}, 1);

    // Back-to-back matr instructions
    set_matr(5'd1, 32'h1, 32'h2);
    hs0 = hs_cnt;
    tick();
    clr_id();
    npu_req_ready = 1'b1;
    tick();
    npu_req_ready = 1'b0;
    npu_done = 1'b1;
    npu_result = 32'h111;
    sb_q.push_back({5'd1, 32'h111});
    tick();
    npu_done = 1'b0;
    set_matr(5'd2, 32'h3, 32'h4);
    #1;
    chk("b2b_wb_valid", {31'd0, wb_valid}, 1);
    chk("b2b_no_retrigger", {31'd0, npu_stall}, 0);
    chk("b2b_reqv_wb", {31'd0, npu_req_valid}, 0);
    tick();
    chk("b2b_second_hit", {31'd0, npu_stall}, 1);
    chk("b2b_wb_off", {31'd0, wb_valid}, 0);
    chk("b2b_reqv_idle", {31'd0, npu_req_valid}, 0);
    tick();
    clr_id();
    npu_req_ready = 1'b1;
    #1;
    chk("b2b_reqv2", {31'd0, npu_req_valid}, 1);
    chk("b2b_req_a2", npu_req_a, 32'h3);
    tick();
    npu_req_ready = 1'b0;
    npu_done = 1'b1;
    npu_result = 32'h222;
    sb_q.push_back({5'd2, 32'h222});
    tick();
    npu_done = 1'b0;
    tick();
    chk("b2b_opcount", {16'd0, op_count}, 4);
    chk("b2b_two_hs", hs_cnt - hs0, 2);

    // Non-matr R-type (add) must not stall
    id_valid  = 1'b1;
    id_opcode = 7'b0110011;
    id_funct7 = 7'b0000000;
    #1;
    chk("add_no_stall", {31'd0, npu_stall}, 0);
    tick();
    chk("add_no_req", {31'd0, npu_req_valid}, 0);
    chk("add_no_stall2", {31'd0, npu_stall}, 0);
    clr_id();

    // Asynchronous reset in WAIT
    set_matr(5'd3, 32'h900, 32'hA00);
    tick();
    clr_id();
    npu_req_ready = 1'b1;
    tick();
    npu_req_ready = 1'b0;
    #1;
    chk("rw_stall_pre", {31'd0, npu_stall}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_stall", {31'd0, npu_stall}, 0);
    chk("rw_ctrl", {31'd0, ctrl_src}, 0);
    chk("rw_reqv", {31'd0, npu_req_valid}, 0);
    chk("rw_req_a", npu_req_a, 0);
    chk("rw_req_b", npu_req_b, 0);
    chk("rw_wb_valid", {31'd0, wb_valid}, 0);
    chk("rw_wb_rd", {27'd0, wb_rd}, 0);
    chk("rw_wb_data", wb_data, 0);
    chk("rw_err", {31'd0, npu_err}, 0);
    chk("rw_opcount", {16'd0, op_count}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rw_idle_after", {31'd0, npu_stall}, 0);
    tick();

    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/npu_dispatch_ctrl.md
Name: npu_dispatch_ctrl

Overview:
- Drives the control decoder's `CtrlSrc` and `npu_stall` inputs. It detects matrix (matr) R-type instructions in ID and offloads them to the NPU over a valid/ready request plus a done/result return.
- Freezes the pipeline while the NPU works, then retires the instruction through its own writeback port.
- Sits between the ID stage, the control decoder and the NPU wrapper.

Parameters:
- MATR_FUNCT7, 7'b0000011, funct7 code identifying matr within opcode 7'b0110011.
- TIMEOUT, 1024, maximum cycles from entering ISSUE to `npu_done` before abort.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a valid instruction
- id_opcode  in  7  instruction[6:0]
- id_funct7  in  7  instruction[31:25]
- id_rd  in  5  destination register
- rs1_data  in  32  operand A (NPU source address)
- rs2_data  in  32  operand B (NPU destination/config word)
- flush  in  1  branch flush of ID
- npu_stall  out  1  pipeline freeze to PC/IF/ID and control decoder
- ctrl_src  out  1  bubble request to control decoder (zeroes control)
- npu_req_valid  out  1  request to NPU
- npu_req_ready  in  1  NPU accepts request
- npu_req_a  out  32  latched rs1_data
- npu_req_b  out  32  latched rs2_data
- npu_done  in  1  one-cycle NPU completion pulse
- npu_result  in  32  result, valid with npu_done
- wb_valid  out  1  one-cycle register-file write strobe
- wb_rd  out  5  write register
- wb_data  out  32  write data
- npu_err  out  1  sticky timeout flag
- op_count  out  CNT_W  completed-operation counter

Behaviour:
- Hit definition: hit = id_valid & opcode==7'b0110011 & funct7==MATR_FUNCT7 & !flush.
- FSM states: IDLE, ISSUE, WAIT, WB. Reset (async, rst_n low) → IDLE, all outputs 0, latches 0, npu_err 0, op_count 0, drop 0. Reset mid-operation abandons the transaction immediately.
- npu_stall is combinational: (IDLE & hit) | ISSUE | WAIT. It is asserted in the same cycle matr is first seen in ID.
- IDLE & hit: latch rs1_data, rs2_data, id_rd; clear the timeout counter; next state ISSUE.
- ISSUE: npu_req_valid=1; npu_req_a/b stable until the handshake.
  - valid & ready → WAIT.
  - flush in ISSUE with no handshake that cycle → IDLE; no request is ever accepted.
  - flush coincident with handshake → WAIT with drop=1.
- WAIT: npu_req_valid=0.
  - npu_done → capture npu_result; next WB (or IDLE if drop=1, clearing drop).
  - flush while in WAIT sets drop=1; the NPU cannot be cancelled.
- Timeout: counter runs in ISSUE and WAIT. On reaching TIMEOUT-1 without done, set npu_err, deassert npu_req_valid, and go to WB with wb_data=0 (IDLE if drop). A late npu_done arriving in IDLE is ignored.
  - Simultaneous done and timeout: done wins; npu_err is not set.
- WB, exactly one cycle:
  - wb_valid=1, wb_rd=latched rd, wb_data=result.
  - ctrl_src=1, npu_stall=0, so the decoder zeroes control for the retiring matr and the ALU path writes nothing.
  - op_count += 1, wrapping modulo 2^CNT_W; not incremented on timeout or drop.
  - Next state IDLE.
- No re-trigger: hit is evaluated only in IDLE, so the retiring instruction in WB never re-issues. The earliest next issue is the cycle after WB.
- Outputs: wb_valid, wb_rd, wb_data, npu_req_a/b are registered. npu_stall and ctrl_src are decoded from state (npu_stall also depends on hit). wb_rd and wb_data are 0 outside WB.

Decomposition:
- Shared package: opcode constant OP_RTYPE=7'b0110011, MATR_FUNCT7, and FSM state encoding (2-bit localparams).
- One sub-module, npu_timeout_cnt: clear/enable/expire counter, parameterized by TIMEOUT.

Test Plan:
- Basic op: matr with rd=5, rs1=0x100, rs2=0x200; ready on the first ISSUE cycle; done with result 0xDEADBEEF 4 cycles later → npu_stall high from the hit cycle through WAIT; then one cycle of wb_valid/ctrl_src with wb_rd=5 and wb_data=0xDEADBEEF; op_count=1.
- Backpressure: ready low for 3 cycles → npu_req_valid held with npu_req_a/b stable at 0x100/0x200 for 4 cycles; exactly one handshake.
- Flush: flush in ISSUE before ready → IDLE, no request accepted, no wb_valid. Flush in WAIT → done consumed, no wb_valid, op_count unchanged.
- Timeout: TIMEOUT=16, no done → npu_err=1 after 16 cycles; WB with wb_data=0; a later spurious done is ignored.
- Back-to-back: two consecutive matr instructions → two distinct issues separated by a WB cycle; op_count=2; non-matr opcode (add, funct7=0) → no stall.
- Reset: rst_n low during WAIT → all outputs 0 immediately; state IDLE; npu_err and op_count cleared.
